// File: rtl/serial_word_loader_if.sv
// Serial input and parallel load-strobe signals of serial_word_loader.
// The master drives the serial stream and the slave (the loader) drives the parallel side.
interface serial_word_loader_if #(
    parameter int WIDTH = 8
);
    logic             SerIn;
    logic             SerValidN;
    logic [WIDTH-1:0] Dout;
    logic             EnbarOut;
    logic             Busy;
    logic             ParErr;

    modport master (
        output SerIn, SerValidN,
        input  Dout, EnbarOut, Busy, ParErr
    );

    modport slave (
        input  SerIn, SerValidN,
        output Dout, EnbarOut, Busy, ParErr
    );
endinterface

// File: rtl/serial_word_loader.sv
// Serial-to-parallel word loader that feeds a negative-edge register bank through a one-cycle low load strobe.
// Optional macro PARITY_CHECK_EN: each frame carries one trailing even-parity bit, and a bad frame is dropped with a ParErr pulse.
module serial_word_loader #(
    parameter int WIDTH = 8
) (
    input  logic                 ClkN,
    input  logic                 ClrN,
    serial_word_loader_if.slave  bus,
    output logic [1:0]           state_dbg
);
    // Handshake: on a falling edge, SerIn is taken only when SerValidN is 0.
    // There is no back-pressure, so every qualified bit is consumed.
    // EnbarOut goes low for one cycle on the edge that completes a word.

`ifdef PARITY_CHECK_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dout_q;
    logic             enbar_q;
    logic             busy_q;
    logic             accept;
    logic             last_bit;
    logic             frame_ok;
    logic [WIDTH-1:0] full_word;

    assign accept   = ~bus.SerValidN;
    assign last_bit = (cnt == LAST_IDX);

    always_comb begin
        full_word = sr;
`ifdef PARITY_CHECK_EN
        frame_ok  = ~((^sr) ^ bus.SerIn);
`else
        // The final data bit has not yet been written to sr, so it is taken straight from SerIn.
        full_word[WIDTH-1] = bus.SerIn;
        frame_ok  = 1'b1;
`endif
    end

`ifdef PARITY_CHECK_EN
    logic par_err_q;
    assign bus.ParErr = par_err_q;
`else
    assign bus.ParErr = 1'b0;
`endif

    always_ff @(negedge ClkN) begin
        if (!ClrN) begin
            state   <= IDLE;
            sr      <= '0;
            cnt     <= '0;
            dout_q  <= '0;
            enbar_q <= 1'b1;
            busy_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            enbar_q <= 1'b1;
`ifdef PARITY_CHECK_EN
            par_err_q <= 1'b0;
`endif
            case (state)
                SHIFT: begin
                    if (accept) begin
                        if (last_bit) begin
                            cnt    <= '0;
                            busy_q <= 1'b0;
                            if (frame_ok) begin
                                dout_q  <= full_word;
                                enbar_q <= 1'b0;
                                state   <= STROBE;
                            end else begin
`ifdef PARITY_CHECK_EN
                                par_err_q <= 1'b1;
`endif
                                state     <= IDLE;
                            end
                        end else begin
                            sr[cnt[IW-1:0]] <= bus.SerIn;
                            cnt             <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    // IDLE and STROBE both start a new frame here, which allows back-to-back frames.
                    if (accept) begin
                        sr[0]  <= bus.SerIn;
                        cnt    <= CW'(1);
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end else begin
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.Dout     = dout_q;
    assign bus.EnbarOut = enbar_q;
    assign bus.Busy     = busy_q;
    assign state_dbg    = state;
endmodule

// File: tb/tb_serial_word_loader.sv
// Directed bench for serial_word_loader with WIDTH=8 and a 20 ns ClkN period.
// Outputs are sampled 2 ns after each falling edge.
module tb_serial_word_loader;
    localparam int W = 8;
`ifdef PARITY_CHECK_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;

    logic       ClkN;
    logic       ClrN;
    logic [1:0] state_dbg;
    int         checks;
    int         failures;
    logic [W-1:0] last_word;

    serial_word_loader_if #(.WIDTH(W)) bus ();

    serial_word_loader #(.WIDTH(W)) dut (
        .ClkN      (ClkN),
        .ClrN      (ClrN),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial begin
        ClkN = 1'b1;
        forever #10 ClkN = ~ClkN;
    end

    task automatic tick(input logic rst_n, input logic vn, input logic b);
        ClrN          = rst_n;
        bus.SerValidN = vn;
        bus.SerIn     = b;
        @(negedge ClkN);
        #2;
    endtask

    function automatic logic frame_bit(input logic [W-1:0] w, input int i);
        if (i < W) return w[i];
        return ^w;
    endfunction

    task automatic test_reset();
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 11; k++) begin
            if (k > 0) tick(1'b1, 1'b1, 1'b0);
            checks++;
            if (bus.Dout !== 8'h00 || bus.EnbarOut !== 1'b1 || bus.Busy !== 1'b0 ||
                bus.ParErr !== 1'b0 || state_dbg !== S_IDLE) begin
                failures++;
                $display("FAIL reset_idle k=%0d got dout=%h enbar=%b busy=%b perr=%b st=%0d exp 00/1/0/0/0",
                         k, bus.Dout, bus.EnbarOut, bus.Busy, bus.ParErr, state_dbg);
            end
        end
        last_word = 8'h00;
    endtask

    task automatic test_single_frame();
        logic [W-1:0] w = 8'hA5;
        for (int i = 0; i < FL; i++) begin
            tick(1'b1, 1'b0, frame_bit(w, i));
            checks++;
            if (i < FL - 1) begin
                if (bus.Dout !== last_word || bus.EnbarOut !== 1'b1 || bus.Busy !== 1'b1) begin
                    failures++;
                    $display("FAIL single_mid edge=%0d got dout=%h enbar=%b busy=%b exp %h/1/1",
                             i + 1, bus.Dout, bus.EnbarOut, bus.Busy, last_word);
                end
            end else if (bus.Dout !== w || bus.EnbarOut !== 1'b0 || bus.Busy !== 1'b0) begin
                failures++;
                $display("FAIL single_done got dout=%h enbar=%b busy=%b exp %h/0/0",
                         bus.Dout, bus.EnbarOut, bus.Busy, w);
            end
        end
        last_word = w;
        tick(1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.EnbarOut !== 1'b1 || bus.Busy !== 1'b0 || bus.Dout !== w || state_dbg !== S_IDLE) begin
            failures++;
            $display("FAIL single_after got enbar=%b busy=%b dout=%h st=%0d exp 1/0/%h/0",
                     bus.EnbarOut, bus.Busy, bus.Dout, state_dbg, w);
        end
    endtask

    task automatic test_gapped();
        logic [W-1:0] w = 8'h3C;
        for (int i = 0; i < FL; i++) begin
            if (i == 4) begin
                for (int g = 0; g < 3; g++) begin
                    tick(1'b1, 1'b1, 1'b1);
                    checks++;
                    if (bus.EnbarOut !== 1'b1 || bus.Busy !== 1'b1 || bus.Dout !== last_word) begin
                        failures++;
                        $display("FAIL gap_hold g=%0d got enbar=%b busy=%b dout=%h exp 1/1/%h",
                                 g, bus.EnbarOut, bus.Busy, bus.Dout, last_word);
                    end
                end
            end
            tick(1'b1, 1'b0, frame_bit(w, i));
            checks++;
            if (i < FL - 1) begin
                if (bus.Dout !== last_word || bus.EnbarOut !== 1'b1) begin
                    failures++;
                    $display("FAIL gap_mid bit=%0d got dout=%h enbar=%b exp %h/1",
                             i, bus.Dout, bus.EnbarOut, last_word);
                end
            end else if (bus.Dout !== w || bus.EnbarOut !== 1'b0) begin
                failures++;
                $display("FAIL gap_done got dout=%h enbar=%b exp %h/0", bus.Dout, bus.EnbarOut, w);
            end
        end
        last_word = w;
        tick(1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [2];
        int edge_no = 0;
        int strobe_edge [2];
        words[0] = 8'hFF;
        words[1] = 8'h01;
        strobe_edge[0] = -1;
        strobe_edge[1] = -1;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < FL; i++) begin
                tick(1'b1, 1'b0, frame_bit(words[f], i));
                edge_no++;
                if (bus.EnbarOut === 1'b0) strobe_edge[f] = edge_no;
                checks++;
                if (i < FL - 1) begin
                    if (bus.Dout !== last_word || bus.EnbarOut !== 1'b1 || bus.Busy !== 1'b1 ||
                        state_dbg !== S_SHIFT) begin
                        failures++;
                        $display("FAIL b2b_mid f=%0d bit=%0d got dout=%h enbar=%b busy=%b st=%0d exp %h/1/1/1",
                                 f, i, bus.Dout, bus.EnbarOut, bus.Busy, state_dbg, last_word);
                    end
                end else if (bus.Dout !== words[f] || bus.EnbarOut !== 1'b0 || bus.Busy !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_done f=%0d got dout=%h enbar=%b busy=%b exp %h/0/0",
                             f, bus.Dout, bus.EnbarOut, bus.Busy, words[f]);
                end
            end
            last_word = words[f];
        end
        checks++;
        if (strobe_edge[1] - strobe_edge[0] !== FL) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d exp=%0d", strobe_edge[1] - strobe_edge[0], FL);
        end
        tick(1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] w = 8'h81;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.Dout !== 8'h00 || bus.Busy !== 1'b0 || bus.EnbarOut !== 1'b1 || state_dbg !== S_IDLE) begin
            failures++;
            $display("FAIL midrst_clear got dout=%h busy=%b enbar=%b st=%0d exp 00/0/1/0",
                     bus.Dout, bus.Busy, bus.EnbarOut, state_dbg);
        end
        for (int i = 0; i < FL; i++) tick(1'b1, 1'b0, frame_bit(w, i));
        checks++;
        if (bus.Dout !== w || bus.EnbarOut !== 1'b0) begin
            failures++;
            $display("FAIL midrst_frame got dout=%h enbar=%b exp %h/0", bus.Dout, bus.EnbarOut, w);
        end
        // Reset on the strobe's following edge, with a valid bit present that must be ignored.
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.Dout !== 8'h00 || bus.EnbarOut !== 1'b1 || bus.Busy !== 1'b0 || state_dbg !== S_IDLE) begin
            failures++;
            $display("FAIL strobe_rst got dout=%h enbar=%b busy=%b st=%0d exp 00/1/0/0",
                     bus.Dout, bus.EnbarOut, bus.Busy, state_dbg);
        end
        last_word = 8'h00;
        tick(1'b1, 1'b1, 1'b0);
    endtask

`ifdef PARITY_CHECK_EN
    task automatic test_parity();
        logic [W-1:0] w = 8'hA5;
        for (int i = 0; i < W; i++) tick(1'b1, 1'b0, w[i]);
        tick(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.Dout !== 8'hA5 || bus.EnbarOut !== 1'b0 || bus.ParErr !== 1'b0) begin
            failures++;
            $display("FAIL par_good got dout=%h enbar=%b perr=%b exp a5/0/0",
                     bus.Dout, bus.EnbarOut, bus.ParErr);
        end
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < W; i++) tick(1'b1, 1'b0, w[i]);
        tick(1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.Dout !== 8'hA5 || bus.EnbarOut !== 1'b1 || bus.ParErr !== 1'b1 || bus.Busy !== 1'b0) begin
            failures++;
            $display("FAIL par_bad got dout=%h enbar=%b perr=%b busy=%b exp a5/1/1/0",
                     bus.Dout, bus.EnbarOut, bus.ParErr, bus.Busy);
        end
        tick(1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.ParErr !== 1'b0 || bus.EnbarOut !== 1'b1 || state_dbg !== S_IDLE) begin
            failures++;
            $display("FAIL par_pulse got perr=%b enbar=%b st=%0d exp 0/1/0",
                     bus.ParErr, bus.EnbarOut, state_dbg);
        end
    endtask
`endif

    initial begin
        checks        = 0;
        failures      = 0;
        last_word     = '0;
        ClrN          = 1'b0;
        bus.SerValidN = 1'b1;
        bus.SerIn     = 1'b0;
        test_reset();
        test_single_frame();
        test_gapped();
        test_back_to_back();
        test_mid_reset();
`ifdef PARITY_CHECK_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
